binary_decoder_seq: RTL and testbench

//  Parametrised, registered binary-to-one-hot decoder with valid/ready handshake
//  and an autonomous scan mode. Generalises the fixed 3-to-8 decoder for select

---
 rtl/binary_decoder_seq.sv | 194 +++++++++++++++++++
 tb/tb_binary_decoder_seq.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/binary_decoder_seq.sv
// ---------------------------------------------------------------------------
// binary_decoder_seq
// Registered binary-to-one-hot decoder with a valid/ready handshake and an
// autonomous scan mode that walks every output with a programmable dwell.
//
// Ports
//   clk        in   1        rising-edge clock
//   rst        in   1        synchronous, active-high reset
//   in_valid   in   1        in_code is valid
//   in_ready   out  1        block accepts in_code this cycle
//   in_code    in   W        binary code to decode
//   out_valid  out  1        out_onehot/out_code hold a decoded word
//   out_ready  in   1        consumer accepts the decoded word
//   out_onehot out  NUM_OUT  one-hot select (inverted when ACTIVE_LOW=1)
//   out_code   out  W        binary index currently driven on out_onehot
//   err        out  1        1-cycle pulse: accepted code was >= NUM_OUT
//   scan_en    in   1        level request for SCAN mode
//   scan_wrap  out  1        1-cycle pulse on first cycle of index 0 after a wrap
// ---------------------------------------------------------------------------
module binary_decoder_seq #(
  parameter int W          = 3,
  parameter int NUM_OUT    = 8,
  parameter int DWELL      = 4,
  parameter int ACTIVE_LOW = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W-1:0]       in_code,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [NUM_OUT-1:0] out_onehot,
  output logic [W-1:0]       out_code,
  output logic               err,
  input  logic               scan_en,
  output logic               scan_wrap
);

  localparam int                 DW          = $clog2(DWELL) + 1;
  localparam logic [DW-1:0]      DWELL_LAST  = DW'(DWELL - 1);
  localparam logic [W-1:0]       IDX_LAST    = W'(NUM_OUT - 1);
  // NUM_OUT may equal 2**W, so range checks are done one bit wider.
  localparam logic [W:0]         NUM_OUT_EXT = (W+1)'(NUM_OUT);
  localparam logic [NUM_OUT-1:0] ONEHOT_IDLE = (ACTIVE_LOW != 0) ?
                                               {NUM_OUT{1'b1}} : {NUM_OUT{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_SCAN = 2'd2
  } state_t;

  state_t               r_state;
  logic                 r_out_valid;
  logic [NUM_OUT-1:0]   r_onehot;
  logic [W-1:0]         r_out_code;
  logic                 r_err;
  logic                 r_scan_wrap;
  logic [W-1:0]         r_scan_idx;
  logic [DW-1:0]        r_dwell;

  logic                 w_in_ready;
  logic                 w_accept;
  logic                 w_idx_last;
  logic [W-1:0]         w_idx_next;

  // One-hot decode with output polarity applied; out-of-range codes map to idle.
  function automatic logic [NUM_OUT-1:0] f_decode(input logic [W-1:0] code);
    logic [NUM_OUT-1:0] v;
    v = {NUM_OUT{1'b0}};
    for (int k = 0; k < NUM_OUT; k++) begin
      v[k] = ({1'b0, code} == (W+1)'(k));
    end
    return (ACTIVE_LOW != 0) ? ~v : v;
  endfunction

  // Code outside the populated output range.
  function automatic logic f_invalid(input logic [W-1:0] code);
    return ({1'b0, code} >= NUM_OUT_EXT);
  endfunction

  // Handshake readiness: scan requests block new words; HOLD is a one-deep register.
  always_comb begin
    w_in_ready = 1'b0;
    case (r_state)
      ST_IDLE: w_in_ready = ~scan_en;
      ST_HOLD: w_in_ready = out_ready & ~scan_en;
      ST_SCAN: w_in_ready = 1'b0;
      default: w_in_ready = 1'b0;
    endcase
  end

  assign w_accept   = in_valid & w_in_ready;
  assign w_idx_last = (r_scan_idx == IDX_LAST);
  assign w_idx_next = w_idx_last ? {W{1'b0}} : (r_scan_idx + W'(1));

  // Main FSM: state, registered outputs, scan index and dwell counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_out_valid <= 1'b0;
      r_onehot    <= ONEHOT_IDLE;
      r_out_code  <= {W{1'b0}};
      r_err       <= 1'b0;
      r_scan_wrap <= 1'b0;
      r_scan_idx  <= {W{1'b0}};
      r_dwell     <= {DW{1'b0}};
    end else begin
      r_err       <= 1'b0;
      r_scan_wrap <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (scan_en) begin
            r_state     <= ST_SCAN;
            r_out_valid <= 1'b0;
            r_scan_idx  <= {W{1'b0}};
            r_dwell     <= {DW{1'b0}};
            r_out_code  <= {W{1'b0}};
            r_onehot    <= f_decode({W{1'b0}});
          end else if (w_accept) begin
            r_state     <= ST_HOLD;
            r_out_valid <= 1'b1;
            r_out_code  <= in_code;
            r_onehot    <= f_decode(in_code);
            r_err       <= f_invalid(in_code);
          end else begin
            r_state     <= ST_IDLE;
          end
        end
        ST_HOLD: begin
          if (!out_ready) begin
            // Consumer stalled: everything holds, a scan request waits.
            r_state     <= ST_HOLD;
          end else if (w_accept) begin
            r_state     <= ST_HOLD;
            r_out_valid <= 1'b1;
            r_out_code  <= in_code;
            r_onehot    <= f_decode(in_code);
            r_err       <= f_invalid(in_code);
          end else if (scan_en) begin
            r_state     <= ST_SCAN;
            r_out_valid <= 1'b0;
            r_scan_idx  <= {W{1'b0}};
            r_dwell     <= {DW{1'b0}};
            r_out_code  <= {W{1'b0}};
            r_onehot    <= f_decode({W{1'b0}});
          end else begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_onehot    <= ONEHOT_IDLE;
          end
        end
        ST_SCAN: begin
          if (!scan_en) begin
            // Abort immediately; the current dwell is not completed.
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_onehot    <= ONEHOT_IDLE;
            r_out_code  <= {W{1'b0}};
            r_scan_idx  <= {W{1'b0}};
            r_dwell     <= {DW{1'b0}};
          end else if (r_dwell == DWELL_LAST) begin
            r_state     <= ST_SCAN;
            r_dwell     <= {DW{1'b0}};
            r_scan_idx  <= w_idx_next;
            r_out_code  <= w_idx_next;
            r_onehot    <= f_decode(w_idx_next);
            r_scan_wrap <= w_idx_last;
          end else begin
            r_state     <= ST_SCAN;
            r_dwell     <= r_dwell + DW'(1);
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_out_valid <= 1'b0;
          r_onehot    <= ONEHOT_IDLE;
          r_out_code  <= {W{1'b0}};
          r_scan_idx  <= {W{1'b0}};
          r_dwell     <= {DW{1'b0}};
        end
      endcase
    end
  end

  assign in_ready   = w_in_ready;
  assign out_valid  = r_out_valid;
  assign out_onehot = r_onehot;
  assign out_code   = r_out_code;
  assign err        = r_err;
  assign scan_wrap  = r_scan_wrap;

endmodule

// File: tb/tb_binary_decoder_seq.sv
// ---------------------------------------------------------------------------
// tb_binary_decoder_seq
// Directed bench driving three decoder configurations from shared inputs:
//   dut_a: W=3, NUM_OUT=8, DWELL=4, active-high
//   dut_b: W=3, NUM_OUT=6, DWELL=1, active-high (invalid codes, fast scan)
//   dut_c: W=3, NUM_OUT=8, DWELL=4, active-low
// ---------------------------------------------------------------------------
module tb_binary_decoder_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [2:0] in_code;
  logic       out_ready;
  logic       scan_en;

  logic       a_in_ready, a_out_valid, a_err, a_scan_wrap;
  logic [7:0] a_onehot;
  logic [2:0] a_code;
  logic       b_in_ready, b_out_valid, b_err, b_scan_wrap;
  logic [5:0] b_onehot;
  logic [2:0] b_code;
  logic       c_in_ready, c_out_valid, c_err, c_scan_wrap;
  logic [7:0] c_onehot;
  logic [2:0] c_code;

  int n_checks = 0;
  int n_errs   = 0;

  always #5 clk = ~clk;

  binary_decoder_seq #(.W(3), .NUM_OUT(8), .DWELL(4), .ACTIVE_LOW(0)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_code(in_code), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_onehot(a_onehot), .out_code(a_code), .err(a_err),
    .scan_en(scan_en), .scan_wrap(a_scan_wrap));

  binary_decoder_seq #(.W(3), .NUM_OUT(6), .DWELL(1), .ACTIVE_LOW(0)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_code(in_code), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_onehot(b_onehot), .out_code(b_code), .err(b_err),
    .scan_en(scan_en), .scan_wrap(b_scan_wrap));

  binary_decoder_seq #(.W(3), .NUM_OUT(8), .DWELL(4), .ACTIVE_LOW(1)) dut_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c_in_ready),
    .in_code(in_code), .out_valid(c_out_valid), .out_ready(out_ready),
    .out_onehot(c_onehot), .out_code(c_code), .err(c_err),
    .scan_en(scan_en), .scan_wrap(c_scan_wrap));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; sample/drive point is 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int ia, ib;
    rst = 1'b1; in_valid = 1'b0; in_code = 3'd0; out_ready = 1'b1; scan_en = 1'b0;
    tick(); tick();
    rst = 1'b0;
    // Reset state
    check("rst a_valid", 32'(a_out_valid), 32'd0);
    check("rst a_onehot", 32'(a_onehot), 32'h00);
    check("rst a_code", 32'(a_code), 32'd0);
    check("rst a_err", 32'(a_err), 32'd0);
    check("rst a_wrap", 32'(a_scan_wrap), 32'd0);
    check("rst c_onehot", 32'(c_onehot), 32'hFF);
    #1;
    check("rst a_ready", 32'(a_in_ready), 32'd1);

    // Test 1: single word, code 5
    in_code = 3'd5; in_valid = 1'b1;
    #1;
    check("t1 ready", 32'(a_in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("t1 a_valid", 32'(a_out_valid), 32'd1);
    check("t1 a_onehot", 32'(a_onehot), 32'h20);
    check("t1 a_code", 32'(a_code), 32'd5);
    check("t1 a_err", 32'(a_err), 32'd0);
    check("t1 c_onehot", 32'(c_onehot), 32'hDF);
    tick();
    check("t1 idle valid", 32'(a_out_valid), 32'd0);
    check("t1 idle onehot", 32'(a_onehot), 32'h00);
    check("t1 idle code", 32'(a_code), 32'd5);
    check("t1 idle c_onehot", 32'(c_onehot), 32'hFF);

    // Test 2: back-to-back 0,7,3
    in_valid = 1'b1; in_code = 3'd0;
    tick();
    check("t2 w0", 32'(a_onehot), 32'h01);
    in_code = 3'd7;
    #1;
    check("t2 ready w0", 32'(a_in_ready), 32'd1);
    tick();
    check("t2 w7", 32'(a_onehot), 32'h80);
    check("t2 w7 valid", 32'(a_out_valid), 32'd1);
    in_code = 3'd3;
    tick();
    check("t2 w3", 32'(a_onehot), 32'h08);
    check("t2 w3 code", 32'(a_code), 32'd3);
    in_valid = 1'b0;
    tick();
    check("t2 idle", 32'(a_out_valid), 32'd0);
    // Repeat with a stall on word 7
    in_valid = 1'b1; in_code = 3'd0;
    tick();
    in_code = 3'd7;
    tick();
    check("t2s w7", 32'(a_onehot), 32'h80);
    out_ready = 1'b0; in_code = 3'd3;
    #1;
    check("t2s ready stall", 32'(a_in_ready), 32'd0);
    tick();
    check("t2s hold onehot", 32'(a_onehot), 32'h80);
    check("t2s hold code", 32'(a_code), 32'd7);
    check("t2s hold valid", 32'(a_out_valid), 32'd1);
    tick();
    check("t2s hold2 onehot", 32'(a_onehot), 32'h80);
    out_ready = 1'b1;
    #1;
    check("t2s ready resume", 32'(a_in_ready), 32'd1);
    tick();
    check("t2s w3", 32'(a_onehot), 32'h08);
    in_valid = 1'b0;
    tick();

    // Test 3: code 6 valid on dut_a, invalid on dut_b (NUM_OUT=6)
    in_valid = 1'b1; in_code = 3'd6;
    tick();
    in_valid = 1'b0;
    check("t3 a_onehot", 32'(a_onehot), 32'h40);
    check("t3 a_err", 32'(a_err), 32'd0);
    check("t3 b_valid", 32'(b_out_valid), 32'd1);
    check("t3 b_onehot", 32'(b_onehot), 32'h00);
    check("t3 b_code", 32'(b_code), 32'd6);
    check("t3 b_err", 32'(b_err), 32'd1);
    tick();
    check("t3 b_err clr", 32'(b_err), 32'd0);
    check("t3 b_valid clr", 32'(b_out_valid), 32'd0);

    // Test 4: scan for 40 cycles
    scan_en = 1'b1;
    #1;
    check("t4 ready idle scan", 32'(a_in_ready), 32'd0);
    tick();
    for (int cyc = 0; cyc < 40; cyc++) begin
      ia = (cyc / 4) % 8;
      ib = cyc % 6;
      check("t4 a_code", 32'(a_code), 32'(ia));
      check("t4 a_onehot", 32'(a_onehot), 32'd1 << ia);
      check("t4 a_wrap", 32'(a_scan_wrap), (cyc == 32) ? 32'd1 : 32'd0);
      check("t4 a_valid", 32'(a_out_valid), 32'd0);
      check("t4 b_code", 32'(b_code), 32'(ib));
      check("t4 b_onehot", 32'(b_onehot), 32'd1 << ib);
      check("t4 b_wrap", 32'(b_scan_wrap), (cyc > 0 && ib == 0) ? 32'd1 : 32'd0);
      tick();
    end
    tick();  // mid-dwell of index 2
    check("t4 mid code", 32'(a_code), 32'd2);
    scan_en = 1'b0;
    tick();
    check("t4 exit valid", 32'(a_out_valid), 32'd0);
    check("t4 exit onehot", 32'(a_onehot), 32'h00);
    check("t4 exit code", 32'(a_code), 32'd0);
    check("t4 exit c_onehot", 32'(c_onehot), 32'hFF);
    check("t4 exit ready", 32'(a_in_ready), 32'd1);

    // Test 5: scan request while stalled in HOLD
    in_valid = 1'b1; in_code = 3'd2; out_ready = 1'b0;
    tick();
    in_valid = 1'b0; scan_en = 1'b1;
    tick();
    check("t5 hold valid", 32'(a_out_valid), 32'd1);
    check("t5 hold onehot", 32'(a_onehot), 32'h04);
    check("t5 hold code", 32'(a_code), 32'd2);
    out_ready = 1'b1;
    tick();
    check("t5 scan valid", 32'(a_out_valid), 32'd0);
    check("t5 scan code", 32'(a_code), 32'd0);
    check("t5 scan onehot", 32'(a_onehot), 32'h01);

    // Test 6: reset mid-SCAN, then mid-HOLD
    tick(); tick();
    rst = 1'b1;
    tick();
    check("t6 scan rst onehot", 32'(a_onehot), 32'h00);
    check("t6 scan rst code", 32'(a_code), 32'd0);
    check("t6 scan rst valid", 32'(a_out_valid), 32'd0);
    check("t6 scan rst b_code", 32'(b_code), 32'd0);
    check("t6 scan rst c_onehot", 32'(c_onehot), 32'hFF);
    rst = 1'b0; scan_en = 1'b0;
    in_valid = 1'b1; in_code = 3'd6; out_ready = 1'b0;
    tick();
    check("t6 hold valid", 32'(a_out_valid), 32'd1);
    rst = 1'b1; in_valid = 1'b0;
    tick();
    check("t6 hold rst valid", 32'(a_out_valid), 32'd0);
    check("t6 hold rst onehot", 32'(a_onehot), 32'h00);
    check("t6 hold rst code", 32'(a_code), 32'd0);
    check("t6 hold rst b_err", 32'(b_err), 32'd0);
    rst = 1'b0; out_ready = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
